pll_cfg_responder: RTL and testbench
====================================

# pll_cfg_responder

Avalon-MM slave that terminates the PLL reconfiguration management bus driven by the memory-test frequency sequencer. It stages M/N/C0/K/bandwidth/charge-pump writes, commits them atomically on a start write, holds waitrequest for a reconfiguration busy window, then models a PLL relock interval on `locked`. It serves as the bench model behind the sequencer and as a shadow register that the on-screen frequency display can cross-check.

## Interface
- `BUSY_CYCLES`, 16: cycles `mgmt_waitrequest` stays high after an accepted start write (≥1).
- `LOCK_DELAY`, 64: cycles `locked` stays low after the busy window ends (≥1).
- `CLK_50M`  in  1  clock.
- `RESET`  in  1  reset; synchronous, active-high.
- `mgmt_write`  in  1  write request.
- `mgmt_read`  in  1  read request.
- `mgmt_address`  in  6  register address.
- `mgmt_writedata`  in  32  write data.
- `mgmt_readdata`  out  32  read data, valid with `mgmt_readdatavalid`.
- `mgmt_readdatavalid`  out  1  one-cycle read-data strobe.
- `mgmt_waitrequest`  out  1  request not accepted this cycle.
- `locked`  out  1  modelled PLL lock.
- `act_m`, `act_n`, `act_c0`, `act_k`  out  32 each  committed (active) values.
- `act_bw`  out  4  committed bandwidth; `act_cp`  out  3  committed charge pump.
- `apply_pulse`  out  1  one-cycle strobe on commit.
- `apply_count`  out  8  number of commits, wraps 255→0.
- `err_addr`  out  1  sticky: access to an unmapped address.

## Operation
- Register map (staged = written, active = committed): 0 mode (bit0, R/W); 1 status (RO, bit0 = 1 when FSM is IDLE); 2 start (WO, any data; reads 0); 3 N; 4 M; 5 C (written only when `writedata[22:18]==0`, else ignored, no error); 7 K; 8 BW [3:0]; 9 CP [2:0]. Reads of 3–9 return staged values, zero-extended.
- Unmapped address (6, 10–63) on read or write: `err_addr` set, write dropped, read returns 0 with valid strobe. Cleared only by RESET.
- Accepted = request high and `mgmt_waitrequest` low. Write and read in same cycle: write performed, read dropped (no strobe).
- FSM states: RELOCK, IDLE, BUSY.
  - IDLE: `locked`=1, waitrequest=0. Start write → commit, BUSY.
  - BUSY: waitrequest=1, counter loaded with BUSY_CYCLES−1, decrements; at 0 → RELOCK. No accesses accepted.
  - RELOCK: `locked`=0, waitrequest=0, counter loaded LOCK_DELAY−1; at 0 → IDLE. Staged writes accepted; a start write commits and goes to BUSY (relock restarted after).
- Commit: all six staged registers copied to active in the accept cycle; `apply_pulse` high the following cycle; `apply_count` +1 same cycle as pulse.
- Reset values (staged and active): N 'h10000, M 'h00404, C0 'h20201, K 'h1, BW 7, CP 1, mode 0. After RESET the FSM is in RELOCK (counter LOCK_DELAY−1); `locked`=0, `mgmt_waitrequest`=1 during RESET and 0 the cycle after, `mgmt_readdata`=0, `mgmt_readdatavalid`=0, `apply_pulse`=0, `apply_count`=0, `err_addr`=0.
- RESET mid-BUSY: all state returns to reset values; in-flight staged values lost.

## Timing
- Staged write visible to reads the cycle after acceptance.
- Read latency 1: `mgmt_readdata`/`mgmt_readdatavalid` registered, cycle after acceptance; readdata holds until next read.
- Start accepted at cycle t: `act_*` and waitrequest=1 at t+1, `apply_pulse` at t+1 only; waitrequest falls at t+1+BUSY_CYCLES; `locked` falls at t+1 (BUSY counts as unlocked) and rises at t+1+BUSY_CYCLES+LOCK_DELAY.
- Counters are $clog2(max(BUSY_CYCLES,LOCK_DELAY))+1 bits, no wrap within a phase.

## Test plan
- Reset: hold RESET 3 cycles, release → `locked`=0 for 64 cycles then 1; read addr 4 returns 'h00404; `apply_count`=0.
- Full sequence: writes 0←0, 4←'h167, 7←'hB33332DD, 3←'h10000, 5←'h20302, 9←1, 8←7, 2←0 → `act_m`='h167, `act_k`='hB33332DD, `act_c0`='h20302; `apply_pulse` one cycle; waitrequest high exactly 16 cycles; `locked` low 80 cycles.
- Stall: write 4←'h150 issued during BUSY held until waitrequest falls → accepted first RELOCK cycle; `act_m` unchanged until next start.
- C select: write 5←'h40302 → staged C0 unchanged, `err_addr`=0; write 6←'h1 and read 12 → `err_addr`=1, read returns 0 with valid.
- Collision/wrap: simultaneous read+write addr 4 → write lands, no `mgmt_readdatavalid`; 256 start writes → `apply_count` wraps to 0.
- RESET asserted at BUSY cycle 5 → waitrequest high during reset, active regs back to reset values, `apply_count`=0.

Source files
------------

// File: rtl/pll_cfg_responder.sv
// Avalon-MM terminator for the PLL reconfiguration bus: stages divider/loop settings,
// commits them on a start write, then models the busy window and relock interval.
module pll_cfg_responder #(
    parameter int BUSY_CYCLES = 16,
    parameter int LOCK_DELAY  = 64
) (
    input  logic        CLK_50M,
    input  logic        RESET,
    input  logic        mgmt_write,
    input  logic        mgmt_read,
    input  logic [5:0]  mgmt_address,
    input  logic [31:0] mgmt_writedata,
    output logic [31:0] mgmt_readdata,
    output logic        mgmt_readdatavalid,
    output logic        mgmt_waitrequest,
    output logic        locked,
    output logic [31:0] act_m,
    output logic [31:0] act_n,
    output logic [31:0] act_c0,
    output logic [31:0] act_k,
    output logic [3:0]  act_bw,
    output logic [2:0]  act_cp,
    output logic        apply_pulse,
    output logic [7:0]  apply_count,
    output logic        err_addr
);

    localparam int MAXC = (BUSY_CYCLES > LOCK_DELAY) ? BUSY_CYCLES : LOCK_DELAY;
    localparam int CW   = $clog2(MAXC) + 1;
    localparam logic [CW-1:0] BUSY_LD = CW'(BUSY_CYCLES - 1);
    localparam logic [CW-1:0] LOCK_LD = CW'(LOCK_DELAY - 1);

    localparam logic [5:0] A_MODE   = 6'd0;
    localparam logic [5:0] A_STATUS = 6'd1;
    localparam logic [5:0] A_START  = 6'd2;
    localparam logic [5:0] A_N      = 6'd3;
    localparam logic [5:0] A_M      = 6'd4;
    localparam logic [5:0] A_C      = 6'd5;
    localparam logic [5:0] A_K      = 6'd7;
    localparam logic [5:0] A_BW     = 6'd8;
    localparam logic [5:0] A_CP     = 6'd9;

    localparam logic [31:0] RST_N  = 32'h0001_0000;
    localparam logic [31:0] RST_M  = 32'h0000_0404;
    localparam logic [31:0] RST_C0 = 32'h0002_0201;
    localparam logic [31:0] RST_K  = 32'h0000_0001;
    localparam logic [3:0]  RST_BW = 4'd7;
    localparam logic [2:0]  RST_CP = 3'd1;

    typedef enum logic [1:0] {
        S_RELOCK,
        S_IDLE,
        S_BUSY
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;

    logic        r_mode;
    logic [31:0] r_n, r_m, r_c0, r_k;
    logic [3:0]  r_bw;
    logic [2:0]  r_cp;
    logic [31:0] r_act_n, r_act_m, r_act_c0, r_act_k;
    logic [3:0]  r_act_bw;
    logic [2:0]  r_act_cp;
    logic [31:0] r_rdata;
    logic        r_rdv;
    logic        r_pulse;
    logic [7:0]  r_apply_cnt;
    logic        r_err;

    logic        w_wait;
    logic        w_acc_wr;
    logic        w_acc_rd;
    logic        w_mapped;
    logic        w_start;
    logic        w_c_sel_ok;
    logic [31:0] w_rdata;

    // RESET forces waitrequest directly so the bus stalls for the whole reset window.
    assign w_wait     = RESET | (r_state == S_BUSY);
    assign w_acc_wr   = mgmt_write & ~w_wait;
    assign w_acc_rd   = mgmt_read & ~mgmt_write & ~w_wait;
    assign w_start    = w_acc_wr & (mgmt_address == A_START);
    assign w_c_sel_ok = (mgmt_writedata[22:18] == 5'd0);

    always_comb begin
        w_mapped = 1'b0;
        case (mgmt_address)
            A_MODE, A_STATUS, A_START, A_N, A_M, A_C, A_K, A_BW, A_CP: w_mapped = 1'b1;
            default: w_mapped = 1'b0;
        endcase
    end

    always_comb begin
        w_rdata = 32'd0;
        case (mgmt_address)
            A_MODE:   w_rdata = {31'd0, r_mode};
            A_STATUS: w_rdata = {31'd0, (r_state == S_IDLE)};
            A_N:      w_rdata = r_n;
            A_M:      w_rdata = r_m;
            A_C:      w_rdata = r_c0;
            A_K:      w_rdata = r_k;
            A_BW:     w_rdata = {28'd0, r_bw};
            A_CP:     w_rdata = {29'd0, r_cp};
            default:  w_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            r_state <= S_RELOCK;
            r_cnt   <= LOCK_LD;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A start during RELOCK preempts the relock and restarts the busy window.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = BUSY_LD;
                end
            end
            S_RELOCK: begin
                if (w_start) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = BUSY_LD;
                end else if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            S_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_RELOCK;
                    w_cnt_nxt   = LOCK_LD;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_RELOCK;
                w_cnt_nxt   = LOCK_LD;
            end
        endcase
    end

    always_ff @(posedge CLK_50M) begin
        if (RESET) begin
            r_mode      <= 1'b0;
            r_n         <= RST_N;
            r_m         <= RST_M;
            r_c0        <= RST_C0;
            r_k         <= RST_K;
            r_bw        <= RST_BW;
            r_cp        <= RST_CP;
            r_act_n     <= RST_N;
            r_act_m     <= RST_M;
            r_act_c0    <= RST_C0;
            r_act_k     <= RST_K;
            r_act_bw    <= RST_BW;
            r_act_cp    <= RST_CP;
            r_rdata     <= 32'd0;
            r_rdv       <= 1'b0;
            r_pulse     <= 1'b0;
            r_apply_cnt <= 8'd0;
            r_err       <= 1'b0;
        end else begin
            r_pulse <= w_start;
            r_rdv   <= w_acc_rd;
            if (w_acc_rd)
                r_rdata <= w_rdata;
            if ((w_acc_wr | w_acc_rd) & ~w_mapped)
                r_err <= 1'b1;
            if (w_acc_wr) begin
                case (mgmt_address)
                    A_MODE: r_mode <= mgmt_writedata[0];
                    A_N:    r_n    <= mgmt_writedata;
                    A_M:    r_m    <= mgmt_writedata;
                    A_C:    if (w_c_sel_ok) r_c0 <= mgmt_writedata;
                    A_K:    r_k    <= mgmt_writedata;
                    A_BW:   r_bw   <= mgmt_writedata[3:0];
                    A_CP:   r_cp   <= mgmt_writedata[2:0];
                    default: ;
                endcase
            end
            // Commit copies the staged set as it stood before this cycle's edge.
            if (w_start) begin
                r_act_n     <= r_n;
                r_act_m     <= r_m;
                r_act_c0    <= r_c0;
                r_act_k     <= r_k;
                r_act_bw    <= r_bw;
                r_act_cp    <= r_cp;
                r_apply_cnt <= r_apply_cnt + 8'd1;
            end
        end
    end

    assign mgmt_readdata      = r_rdata;
    assign mgmt_readdatavalid = r_rdv;
    assign mgmt_waitrequest   = w_wait;
    assign locked             = ~RESET & (r_state == S_IDLE);
    assign act_n              = r_act_n;
    assign act_m              = r_act_m;
    assign act_c0             = r_act_c0;
    assign act_k              = r_act_k;
    assign act_bw             = r_act_bw;
    assign act_cp             = r_act_cp;
    assign apply_pulse        = r_pulse;
    assign apply_count        = r_apply_cnt;
    assign err_addr           = r_err;

endmodule

// File: tb/tb_pll_cfg_responder.sv
// Bench for pll_cfg_responder: timestamp-based reference model checked every cycle,
// a register read-back vector table, directed timing sequences and random traffic.
module tb_pll_cfg_responder;
    localparam int B = 16;
    localparam int L = 64;

    logic        CLK_50M = 1'b0;
    logic        RESET = 1'b1;
    logic        mgmt_write = 1'b0;
    logic        mgmt_read = 1'b0;
    logic [5:0]  mgmt_address = 6'd0;
    logic [31:0] mgmt_writedata = 32'd0;
    logic [31:0] mgmt_readdata;
    logic        mgmt_readdatavalid;
    logic        mgmt_waitrequest;
    logic        locked;
    logic [31:0] act_m, act_n, act_c0, act_k;
    logic [3:0]  act_bw;
    logic [2:0]  act_cp;
    logic        apply_pulse;
    logic [7:0]  apply_count;
    logic        err_addr;

    pll_cfg_responder #(.BUSY_CYCLES(B), .LOCK_DELAY(L)) dut (
        .CLK_50M(CLK_50M), .RESET(RESET),
        .mgmt_write(mgmt_write), .mgmt_read(mgmt_read),
        .mgmt_address(mgmt_address), .mgmt_writedata(mgmt_writedata),
        .mgmt_readdata(mgmt_readdata), .mgmt_readdatavalid(mgmt_readdatavalid),
        .mgmt_waitrequest(mgmt_waitrequest), .locked(locked),
        .act_m(act_m), .act_n(act_n), .act_c0(act_c0), .act_k(act_k),
        .act_bw(act_bw), .act_cp(act_cp),
        .apply_pulse(apply_pulse), .apply_count(apply_count), .err_addr(err_addr)
    );

    always #10 CLK_50M = ~CLK_50M;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: registers kept per address, timing kept as absolute cycle stamps.
    logic [31:0] m_reg [0:9];
    logic [31:0] m_act [0:9];
    logic [31:0] m_rdata;
    logic        m_rdv, m_pulse, m_err, m_last_rst;
    logic [7:0]  m_count;
    longint      cyc = 0, busy_end = 0, lock_rise = 0;

    function automatic bit mapped(input logic [5:0] a);
        return (a <= 6'd9) && (a != 6'd6);
    endfunction

    function automatic logic [31:0] wmask(input logic [5:0] a);
        case (a)
            6'd0:    return 32'h1;
            6'd8:    return 32'hF;
            6'd9:    return 32'h7;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 10; i++) m_reg[i] = 32'd0;
        m_reg[3] = 32'h10000; m_reg[4] = 32'h404; m_reg[5] = 32'h20201;
        m_reg[7] = 32'h1;     m_reg[8] = 32'h7;   m_reg[9] = 32'h1;
        for (int i = 0; i < 10; i++) m_act[i] = m_reg[i];
        m_rdata = 32'd0; m_rdv = 1'b0; m_pulse = 1'b0; m_err = 1'b0; m_count = 8'd0;
    endtask

    task automatic model_step(input bit w, input bit r, input logic [5:0] a,
                              input logic [31:0] d, input bit rst);
        bit wt, aw, ar;
        if (rst) begin
            model_reset();
            cyc++;
            busy_end   = cyc;
            lock_rise  = cyc + L;
            m_last_rst = 1'b1;
        end else begin
            wt = cyc < busy_end;
            aw = w && !wt;
            ar = r && !w && !wt;
            m_pulse = 1'b0;
            m_rdv   = ar;
            if (ar) begin
                if (!mapped(a) || a == 6'd2) m_rdata = 32'd0;
                else if (a == 6'd1)          m_rdata = (cyc >= lock_rise) ? 32'd1 : 32'd0;
                else                         m_rdata = m_reg[a];
            end
            if ((aw || ar) && !mapped(a)) m_err = 1'b1;
            if (aw && mapped(a)) begin
                if (a == 6'd2) begin
                    for (int i = 0; i < 10; i++) m_act[i] = m_reg[i];
                    m_pulse   = 1'b1;
                    m_count   = m_count + 8'd1;
                    busy_end  = cyc + 1 + B;
                    lock_rise = cyc + 1 + B + L;
                end else if (a == 6'd1 || (a == 6'd5 && d[22:18] != 5'd0)) begin
                end else begin
                    m_reg[a] = d & wmask(a);
                end
            end
            cyc++;
            m_last_rst = 1'b0;
        end
    endtask

    task automatic check_cycle();
        bit ew, el;
        ew = m_last_rst || (cyc < busy_end);
        el = !m_last_rst && (cyc >= lock_rise);
        check("ctrl", 160'({mgmt_waitrequest, locked, mgmt_readdatavalid, apply_pulse, err_addr, apply_count}),
                      160'({ew, el, m_rdv, m_pulse, m_err, m_count}));
        check("rdata", 160'(mgmt_readdata), 160'(m_rdata));
        check("act", {8'd0, act_m, act_n, act_c0, act_k, act_bw, act_cp, 2'd0},
                     {8'd0, m_act[4], m_act[3], m_act[5], m_act[7], m_act[8][3:0], m_act[9][2:0], 2'd0});
    endtask

    task automatic tick(input bit w, input bit r, input logic [5:0] a,
                        input logic [31:0] d, input bit rst);
        RESET = rst; mgmt_write = w; mgmt_read = r; mgmt_address = a; mgmt_writedata = d;
        model_step(w, r, a, d, rst);
        @(negedge CLK_50M);
        check_cycle();
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 6'd0, 32'd0, 1'b0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (mgmt_waitrequest && n < 100) begin idle(); n++; end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL wait_ready: waitrequest still %0b after %0d cycles, required 0", mgmt_waitrequest, n);
        end
    endtask

    task automatic wait_locked(output longint seen);
        int n = 0;
        while (!locked && n < 500) begin idle(); n++; end
        seen = cyc;
        if (n >= 500) begin
            checks++; errors++;
            $display("FAIL wait_locked: locked still %0b after %0d cycles, required 1", locked, n);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [5:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    initial begin
        #(20 * 60000);
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   tbl [13];
        int     n, held, pulses;
        longint t0, seen;
        bit     was_wait;

        tbl[0]  = '{1'b1, 6'd0, 32'hFFFF_FFFF, 32'h1};
        tbl[1]  = '{1'b1, 6'd4, 32'h167,       32'h167};
        tbl[2]  = '{1'b1, 6'd7, 32'hB333_32DD, 32'hB333_32DD};
        tbl[3]  = '{1'b1, 6'd3, 32'h10000,     32'h10000};
        tbl[4]  = '{1'b1, 6'd5, 32'h20302,     32'h20302};
        tbl[5]  = '{1'b1, 6'd5, 32'h40302,     32'h20302};
        tbl[6]  = '{1'b1, 6'd9, 32'hFF,        32'h7};
        tbl[7]  = '{1'b1, 6'd8, 32'hFF,        32'hF};
        tbl[8]  = '{1'b1, 6'd9, 32'h1,         32'h1};
        tbl[9]  = '{1'b1, 6'd8, 32'h7,         32'h7};
        tbl[10] = '{1'b1, 6'd0, 32'h0,         32'h0};
        tbl[11] = '{1'b1, 6'd1, 32'hFFFF,      32'h1};
        tbl[12] = '{1'b0, 6'd2, 32'h0,         32'h0};

        // Reset and relock interval
        repeat (3) tick(1'b0, 1'b0, 6'd0, 32'd0, 1'b1);
        check("rst_count", 160'(apply_count), 160'(8'd0));
        n = 0;
        do begin idle(); n++; end while (!locked && n < 200);
        check("rst_lock_low", 160'(n), 160'(L));
        tick(1'b0, 1'b1, 6'd4, 32'd0, 1'b0);
        check("rst_read_m", 160'({mgmt_readdatavalid, mgmt_readdata}), 160'({1'b1, 32'h404}));

        // Register write/read-back table
        foreach (tbl[i]) begin
            if (tbl[i].wr) tick(1'b1, 1'b0, tbl[i].addr, tbl[i].wdata, 1'b0);
            tick(1'b0, 1'b1, tbl[i].addr, 32'd0, 1'b0);
            check($sformatf("tbl%0d", i), 160'(mgmt_readdata), 160'(tbl[i].exp));
        end

        // Commit, busy window, stalled write, relock
        t0 = cyc;
        tick(1'b1, 1'b0, 6'd2, 32'd0, 1'b0);
        pulses = apply_pulse ? 1 : 0;
        check("commit_act", {64'd0, act_m, act_k, act_c0}, {64'd0, 32'h167, 32'hB333_32DD, 32'h20302});
        held = 0;
        do begin
            was_wait = mgmt_waitrequest;
            tick(1'b1, 1'b0, 6'd4, 32'h150, 1'b0);
            if (apply_pulse) pulses++;
            if (was_wait) held++;
        end while (was_wait && held < 100);
        check("busy_len", 160'(held), 160'(B));
        check("stall_act_m", 160'(act_m), 160'(32'h167));
        tick(1'b0, 1'b1, 6'd4, 32'd0, 1'b0);
        check("stall_staged", 160'(mgmt_readdata), 160'(32'h150));
        wait_locked(seen);
        check("lock_low_len", 160'(seen - t0 - 1), 160'(B + L));
        check("pulse_once", 160'(pulses), 160'(1));
        tick(1'b1, 1'b0, 6'd2, 32'd0, 1'b0);
        check("act_m_next", 160'(act_m), 160'(32'h150));
        wait_ready();

        // Unmapped access
        check("err_clear", 160'(err_addr), 160'(1'b0));
        tick(1'b1, 1'b0, 6'd6, 32'h1, 1'b0);
        check("err_set", 160'(err_addr), 160'(1'b1));
        tick(1'b0, 1'b1, 6'd12, 32'd0, 1'b0);
        check("unmapped_rd", 160'({mgmt_readdatavalid, mgmt_readdata}), 160'({1'b1, 32'h0}));

        // Read/write collision
        tick(1'b1, 1'b1, 6'd4, 32'h1A5, 1'b0);
        check("collide_rdv", 160'(mgmt_readdatavalid), 160'(1'b0));
        tick(1'b0, 1'b1, 6'd4, 32'd0, 1'b0);
        check("collide_wr", 160'(mgmt_readdata), 160'(32'h1A5));

        // apply_count wrap from reset
        tick(1'b0, 1'b0, 6'd0, 32'd0, 1'b1);
        for (int i = 0; i < 256; i++) begin
            wait_ready();
            tick(1'b1, 1'b0, 6'd2, 32'd0, 1'b0);
            if (i == 254) check("count_255", 160'(apply_count), 160'(8'd255));
        end
        check("count_wrap", 160'(apply_count), 160'(8'd0));

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            int          sel;
            logic [5:0]  a;
            logic [31:0] d;
            sel = $urandom_range(0, 99);
            d   = $urandom;
            if (sel < 4)       a = 6'd2;
            else if (sel < 10) a = 6'($urandom_range(10, 63));
            else begin
                a = 6'($urandom_range(0, 8));
                if (a >= 6'd6) a = a + 6'd1;
            end
            if (a == 6'd5 && $urandom_range(0, 1) == 0) d[22:18] = 5'd0;
            tick($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, a, d, 1'b0);
        end

        // Reset during busy window
        wait_ready();
        tick(1'b1, 1'b0, 6'd4, 32'h777, 1'b0);
        tick(1'b1, 1'b0, 6'd2, 32'd0, 1'b0);
        repeat (4) idle();
        tick(1'b0, 1'b0, 6'd0, 32'd0, 1'b1);
        check("rst_busy_wait", 160'(mgmt_waitrequest), 160'(1'b1));
        tick(1'b0, 1'b0, 6'd0, 32'd0, 1'b1);
        check("rst_busy_act", {96'd0, act_m, act_n}, {96'd0, 32'h404, 32'h10000});
        check("rst_busy_cnt", 160'(apply_count), 160'(8'd0));
        idle();
        check("rst_busy_wait_lo", 160'(mgmt_waitrequest), 160'(1'b0));
        tick(1'b0, 1'b1, 6'd4, 32'd0, 1'b0);
        check("rst_busy_staged", 160'(mgmt_readdata), 160'(32'h404));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
